// File: rtl/reg_access_pkg.sv
// Shared encodings for the register-bank access controller.
// Operation codes, FSM states and register index constants.
package reg_access_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_DEC   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RSP  = 2'b11
  } state_t;

  localparam int unsigned REG_PC   = 0;
  localparam int unsigned REG_SP   = 1;
  localparam int unsigned REG_DPTR = 2;
  localparam int unsigned REG_A    = 3;
  localparam int unsigned REG_AVI  = 4;
  localparam int unsigned REG_TEMP = 5;
  localparam int unsigned REG_CTE1 = 6;
  localparam int unsigned REG_BUSA = 7;

endpackage

// File: rtl/reg_incdec.sv
// Combinational +1/-1 modulo 2^DATA_WIDTH with a wrap-around flag.
module reg_incdec #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  dec,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  assign y    = dec ? (a - ONE) : (a + ONE);
  assign wrap = dec ? (a == ZERO) : (a == ONES);

endmodule

// File: rtl/reg_access_ctrl.sv
// Initiator-side controller sequencing READ/WRITE/INC/DEC on the register bank.
// Optional write protection of CTE1 (address 6) under `REG_ACCESS_WPROT_EN.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_wrap,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] rb_r_addr,
  input  logic [DATA_WIDTH-1:0] rb_busB,
  output logic                  rb_wr_en,
  output logic [ADDR_WIDTH-1:0] rb_w_addr,
  output logic [DATA_WIDTH-1:0] rb_w_data
);

  state_t                state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wrap_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] incdec_y;
  logic                  incdec_wrap;
  logic                  prot_req;
  logic                  prot_q;

  reg_incdec #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_incdec (
    .a    (rb_busB),
    .dec  (op_q == OP_DEC),
    .y    (incdec_y),
    .wrap (incdec_wrap)
  );

  // Modifying accesses to CTE1 are refused when protection is built in.
`ifdef REG_ACCESS_WPROT_EN
  assign prot_req = (req_addr == ADDR_WIDTH'(REG_CTE1)) && (op_t'(req_op) != OP_READ);
  assign prot_q   = (addr_q == ADDR_WIDTH'(REG_CTE1)) && (op_q != OP_READ);
`else
  assign prot_req = 1'b0;
  assign prot_q   = 1'b0;
`endif

  // Handshake and write strobe decode from state; rst gates them so a
  // reset landing in WR can never let the bank write.
  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RSP) && !rst;
  assign rb_wr_en  = (state == S_WR) && !rst;

  assign rb_r_addr = addr_q;
  assign rb_w_addr = addr_q;
  assign rb_w_data = data_q;
  assign rsp_data  = data_q;
  assign rsp_wrap  = wrap_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_READ;
      addr_q <= '0;
      data_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= op_t'(req_op);
            addr_q <= req_addr;
            data_q <= req_data;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (op_t'(req_op) != OP_WRITE) begin
              state <= S_RD;
            end else if (prot_req) begin
              data_q <= '0;
              err_q  <= 1'b1;
              state  <= S_RSP;
            end else begin
              state <= S_WR;
            end
          end
        end
        S_RD: begin
          if (op_q == OP_READ) begin
            data_q <= rb_busB;
            state  <= S_RSP;
          end else if (prot_q) begin
            data_q <= rb_busB;
            wrap_q <= 1'b0;
            err_q  <= 1'b1;
            state  <= S_RSP;
          end else begin
            data_q <= incdec_y;
            wrap_q <= incdec_wrap;
            state  <= S_WR;
          end
        end
        S_WR: begin
          state <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl with a behavioural 8-entry register bank.
// Honours `REG_ACCESS_WPROT_EN to select the expected CTE1 behaviour.
module tb_reg_access_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       wrap;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_wrap;
  logic       rsp_err;
  logic [2:0] rb_r_addr;
  logic [7:0] rb_busB;
  logic       rb_wr_en;
  logic [2:0] rb_w_addr;
  logic [7:0] rb_w_data;

  logic       pre_en;
  logic [2:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] bank [8];

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         pend = 1'b0;
  int         wr_count = 0;
  logic [2:0] last_w_addr = '0;
  logic [7:0] last_w_data = '0;

  reg_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_wrap  (rsp_wrap),
    .rsp_err   (rsp_err),
    .rb_r_addr (rb_r_addr),
    .rb_busB   (rb_busB),
    .rb_wr_en  (rb_wr_en),
    .rb_w_addr (rb_w_addr),
    .rb_w_data (rb_w_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: combinational read, write at the clock edge.
  assign rb_busB = bank[rb_r_addr];
  always @(posedge clk) begin
    if (pre_en) bank[pre_addr] <= pre_data;
    else if (rb_wr_en) bank[rb_w_addr] <= rb_w_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on first rsp_valid, payload on handshake, write strobes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && req_valid && req_ready) begin
      acc_cyc = cyc;
      pend    = 1'b1;
    end
    if (rb_wr_en) begin
      wr_count++;
      last_w_addr = rb_w_addr;
      last_w_data = rb_w_data;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (pend) begin
          check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
          pend = 1'b0;
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_wrap", 32'(rsp_wrap), 32'(e.wrap));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] ed, input logic ew, input logic ee, input int lat,
                      input bit push, output int waits);
    exp_t e;
    if (push) begin
      e.data = ed; e.wrap = ew; e.err = ee; e.lat = lat;
      sb.push_back(e);
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) check("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int wc0;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wr_en", 32'(rb_wr_en), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // READ reg3
    preload(3'd3, 8'h5A);
    wc0 = wr_count;
    send(2'b00, 3'd3, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();
    check("read_no_write", 32'(wr_count - wc0), 32'd0);

    // WRITE reg1 then read back
    wc0 = wr_count;
    send(2'b01, 3'd1, 8'hC3, 8'hC3, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();
    check("write_pulses", 32'(wr_count - wc0), 32'd1);
    check("write_w_addr", 32'(last_w_addr), 32'd1);
    check("write_w_data", 32'(last_w_data), 32'hC3);
    send(2'b00, 3'd1, 8'h00, 8'hC3, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();

    // INC/DEC with and without wrap
    preload(3'd0, 8'hFF);
    send(2'b10, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3, 1'b1, w);
    wait_done();
    check("inc_bank0", 32'(bank[0]), 32'h00);
    preload(3'd0, 8'h10);
    send(2'b11, 3'd0, 8'h00, 8'h0F, 1'b0, 1'b0, 3, 1'b1, w);
    wait_done();
    check("dec_bank0", 32'(bank[0]), 32'h0F);
    preload(3'd4, 8'h00);
    send(2'b11, 3'd4, 8'h00, 8'hFF, 1'b1, 1'b0, 3, 1'b1, w);
    wait_done();
    check("dec_wrap_bank4", 32'(bank[4]), 32'hFF);

    // Address 7 is an ordinary target
    send(2'b01, 3'd7, 8'h99, 8'h99, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();
    send(2'b00, 3'd7, 8'h00, 8'h99, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();

    // Back-pressure on the response channel
    rsp_ready = 1'b0;
    send(2'b00, 3'd3, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 1'b1, w);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'h5A);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    send(2'b00, 3'd1, 8'h00, 8'hC3, 1'b0, 1'b0, 2, 1'b1, w);
    check("accept_after_release", 32'(w), 32'd0);
    wait_done();

    // Reset while in WR
    preload(3'd2, 8'h11);
    wc0 = wr_count;
    send(2'b01, 3'd2, 8'h55, 8'h00, 1'b0, 1'b0, 0, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    check("rstwr_wr_en", 32'(rb_wr_en), 32'd0);
    check("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwr_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwr_ready_after", 32'(req_ready), 32'd1);
    check("rstwr_bank2", 32'(bank[2]), 32'h11);
    check("rstwr_no_write", 32'(wr_count - wc0), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rstwr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // CTE1 (address 6) protection
    preload(3'd6, 8'h20);
`ifdef REG_ACCESS_WPROT_EN
    send(2'b01, 3'd6, 8'h77, 8'h00, 1'b0, 1'b1, 1, 1'b1, w);
    wait_done();
    check("cte1_bank_kept", 32'(bank[6]), 32'h20);
    send(2'b10, 3'd6, 8'h00, 8'h20, 1'b0, 1'b1, 2, 1'b1, w);
    wait_done();
    check("cte1_inc_kept", 32'(bank[6]), 32'h20);
`else
    send(2'b01, 3'd6, 8'h77, 8'h77, 1'b0, 1'b0, 2, 1'b1, w);
    wait_done();
    check("cte1_bank_written", 32'(bank[6]), 32'h77);
    send(2'b10, 3'd6, 8'h00, 8'h78, 1'b0, 1'b0, 3, 1'b1, w);
    wait_done();
    check("cte1_inc_written", 32'(bank[6]), 32'h78);
`endif

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
